mem_read_responder: RTL and testbench
=====================================

Name: mem_read_responder

Overview:
- Memory-side responder for the accelerator's req/addr/ack/rdata read interface.
- One instance each serves the image, layer-1 weight and layer-2 weight ports; only parameters differ between instances.
- Holds a word array preloaded through a write port, answers each request after a fixed latency with a one-cycle ack, and counts served transactions.

Parameters:
- ADDR_W, 12, request address width (15 for the layer-1 weight instance)
- DATA_W, 32, read/write data width
- DEPTH, 4096, number of implemented words; must be ≤ 2**ADDR_W
- LATENCY, 2, cycles from request acceptance to ack; legal range 1..15

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst_b  in  1  synchronous reset, active-high; the name is kept for codebase consistency, the polarity is high
- req  in  1  read request level from the requester
- addr  in  ADDR_W  read word address; sampled only on acceptance
- ack  out  1  one-cycle pulse; rdata is valid in the same cycle
- rdata  out  DATA_W  read data; holds its value until the next ack
- wr_en  in  1  preload write strobe
- wr_addr  in  ADDR_W  preload address
- wr_data  in  DATA_W  preload data
- busy  out  1  high in WAIT and ACK
- oor  out  1  sticky flag, set when an accepted address is ≥ DEPTH
- txn_count  out  16  number of acks issued; saturates at 16'hFFFF

Behaviour:
- Reset (rst_b=1 at an edge):
  - state←IDLE; ack, busy, oor←0; rdata←0; txn_count←0; latched address←0.
  - Array contents are not cleared.
  - Reset wins over every other event, including a reset in WAIT or ACK: the in-flight transaction is dropped and no ack is issued.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - If req=1: latch addr, load the down-counter with LATENCY-1, go to WAIT.
  - If LATENCY=1, skip WAIT and go straight to ACK, with array read at this edge.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 0, rdata←array[latched addr] at that edge and go to ACK.
  - req and addr are ignored while in WAIT.
- ACK:
  - ack=1 for exactly this one cycle, then go to IDLE.
  - txn_count increments at the edge entering ACK, saturating.
- Latency: with req first high in cycle N (sampled at edge N), ack is high in cycle N+LATENCY.
- Back-to-back: the next request is sampled in the IDLE cycle after ACK. If req is still high there, it starts a new transaction with the current addr. Minimum request period is therefore LATENCY+1 cycles.
- Requester rule: req must drop at the same edge where the requester samples ack=1, otherwise a repeat read occurs. The responder does not detect this.
- Out-of-range: a latched address ≥ DEPTH returns rdata=0, still acks on schedule, and sets oor. oor clears only on reset.
- Preload writes:
  - Accepted in any state: array[wr_addr]←wr_data at the edge.
  - wr_addr ≥ DEPTH is silently dropped.
  - A write and the array read to the same address at the same edge return the old data (read-before-write).
- rdata is registered, with no combinational path from addr to rdata.

Optional Feature:
- Macro: MEMRESP_STALL_EN.
- With the macro defined:
  - Adds input port stall (1 bit).
  - While stall=1 in WAIT, the counter is frozen.
  - A transition to ACK is deferred while stall=1; the array read happens at the edge that finally enters ACK.
  - stall in IDLE or ACK has no effect; an ack already issued is never withdrawn.
- Without the macro: no stall port; latency is always exactly LATENCY.

Test Plan:
- Reset, preload, single read: reset 2 cycles; preload array[5]=32'hDEADBEEF; req=1, addr=5 at cycle 10, held until ack → ack high in cycle 12 only, rdata=32'hDEADBEEF, txn_count=1, busy high in cycles 11-12.
- Back-to-back: preload [0..3]=1,2,3,4; req held high, addr stepping after each ack → acks in cycles t+2, t+5, t+8, t+11 with rdata 1,2,3,4; txn_count=4.
- LATENCY=1 instance, 15-bit address: preload [20000]=32'h0000ABCD; request it → ack the cycle after acceptance, rdata=32'h0000ABCD.
- Out-of-range and preload collision:
  - DEPTH=4000, read addr=4095 → ack on schedule, rdata=0, oor=1 and sticky across a later valid read.
  - wr_en to addr 7 at the same edge as the array read of addr 7 → old value returned.
- Reset mid-operation: assert rst_b in the WAIT cycle → no ack follows; ack=0, busy=0, txn_count=0, oor=0. Preloaded data is still readable afterwards.
- MEMRESP_STALL_EN defined: stall=1 for 3 cycles during WAIT → ack is delayed by exactly 3 cycles, rdata is correct, and only one ack is issued.

Source files
------------

// File: rtl/mem_read_responder.sv
// Memory-side read responder: preloadable word array, fixed-latency registered read, one-cycle ack.
// Optional MEMRESP_STALL_EN adds a stall input that freezes the latency countdown.
module mem_read_responder #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 4096,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_b,
`ifdef MEMRESP_STALL_EN
  input  logic              stall,
`endif
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              oor,
  output logic [15:0]       txn_count
);

  localparam int unsigned IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StAck  = 2'd2;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              oor_q, oor_d;
  logic [15:0]       txn_q, txn_d;
  logic              stall_w;
  logic              enter_ack;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_in_range;
  logic              wr_in_range;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

`ifdef MEMRESP_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  // With LATENCY=1 the read happens at the accepting edge, before addr_q is loaded.
  assign rd_addr     = (state_q == StIdle) ? addr : addr_q;
  assign rd_in_range = in_range(rd_addr);
  assign wr_in_range = in_range(wr_addr);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    oor_d     = oor_q;
    enter_ack = 1'b0;
    case (state_q)
      StIdle: begin
        if (req) begin
          addr_d = addr;
          if (!rd_in_range) oor_d = 1'b1;
          if (LATENCY == 1) begin
            state_d   = StAck;
            enter_ack = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (!stall_w) begin
          if (cnt_q == 4'd1) begin
            state_d   = StAck;
            enter_ack = 1'b1;
            cnt_d     = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (enter_ack) rdata_d = rd_in_range ? mem[rd_addr[IdxW-1:0]] : '0;
  end

  always_comb begin
    txn_d = txn_q;
    if (enter_ack && (txn_q != 16'hFFFF)) txn_d = txn_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      rdata_q <= '0;
      oor_q   <= 1'b0;
      txn_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      oor_q   <= oor_d;
      txn_q   <= txn_d;
    end
  end

  // Array is not reset; nonblocking update gives read-before-write on a same-edge collision.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) mem[wr_addr[IdxW-1:0]] <= wr_data;
  end

  assign ack       = (state_q == StAck);
  assign busy      = (state_q != StIdle);
  assign rdata     = rdata_q;
  assign oor       = oor_q;
  assign txn_count = txn_q;

endmodule

// File: tb/tb_mem_read_responder.sv
// Directed bench for mem_read_responder: a LATENCY=2/DEPTH=4000 instance and a LATENCY=1 15-bit one.
// Stall checks are compiled in when MEMRESP_STALL_EN is defined.
module tb_mem_read_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b = 1'b1;
  logic        req0 = 1'b0, wr_en0 = 1'b0;
  logic [11:0] addr0 = '0, wr_addr0 = '0;
  logic [31:0] wr_data0 = '0;
  logic        ack0, busy0, oor0;
  logic [31:0] rdata0;
  logic [15:0] txn0;

  logic        req1 = 1'b0, wr_en1 = 1'b0;
  logic [14:0] addr1 = '0, wr_addr1 = '0;
  logic [31:0] wr_data1 = '0;
  logic        ack1, busy1, oor1;
  logic [31:0] rdata1;
  logic [15:0] txn1;

`ifdef MEMRESP_STALL_EN
  logic stall0 = 1'b0, stall1 = 1'b0;
`endif

  mem_read_responder #(.ADDR_W(12), .DATA_W(32), .DEPTH(4000), .LATENCY(2)) dut0 (
    .clk(clk), .rst_b(rst_b),
`ifdef MEMRESP_STALL_EN
    .stall(stall0),
`endif
    .req(req0), .addr(addr0), .ack(ack0), .rdata(rdata0),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .busy(busy0), .oor(oor0), .txn_count(txn0)
  );

  mem_read_responder #(.ADDR_W(15), .DATA_W(32), .DEPTH(32768), .LATENCY(1)) dut1 (
    .clk(clk), .rst_b(rst_b),
`ifdef MEMRESP_STALL_EN
    .stall(stall1),
`endif
    .req(req1), .addr(addr1), .ack(ack1), .rdata(rdata1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .busy(busy1), .oor(oor1), .txn_count(txn1)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr0(input logic [11:0] a, input logic [31:0] d);
    wr_en0 = 1'b1; wr_addr0 = a; wr_data0 = d;
    step();
    wr_en0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset for two cycles
    step(); step();
    check("rst_ack", 32'(ack0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_oor", 32'(oor0), 32'd0);
    check("rst_rdata", rdata0, 32'd0);
    check("rst_txn", 32'(txn0), 32'd0);
    rst_b = 1'b0;

    wr0(12'd5, 32'hDEADBEEF);
    wr0(12'd0, 32'd1);
    wr0(12'd1, 32'd2);
    wr0(12'd2, 32'd3);
    wr0(12'd3, 32'd4);
    wr0(12'd7, 32'h77);
    check("idle_after_preload", 32'(busy0), 32'd0);

    // Single read, LATENCY=2
    req0 = 1'b1; addr0 = 12'd5;
    step();
    check("single_wait_ack", 32'(ack0), 32'd0);
    check("single_wait_busy", 32'(busy0), 32'd1);
    step();
    check("single_ack", 32'(ack0), 32'd1);
    check("single_ack_busy", 32'(busy0), 32'd1);
    check("single_rdata", rdata0, 32'hDEADBEEF);
    check("single_txn", 32'(txn0), 32'd1);
    req0 = 1'b0;
    step();
    check("single_done_ack", 32'(ack0), 32'd0);
    check("single_done_busy", 32'(busy0), 32'd0);
    check("single_rdata_hold", rdata0, 32'hDEADBEEF);

    // Back-to-back: period of three cycles
    req0 = 1'b1; addr0 = 12'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("b2b_wait", 32'(ack0), 32'd0);
      step();
      check("b2b_ack", 32'(ack0), 32'd1);
      check("b2b_rdata", rdata0, 32'(i + 1));
      addr0 = 12'(i + 1);
      if (i == 3) req0 = 1'b0;
      step();
      check("b2b_idle", 32'(ack0), 32'd0);
    end
    check("b2b_txn", 32'(txn0), 32'd5);

    // Out-of-range read
    req0 = 1'b1; addr0 = 12'd4095;
    step(); step();
    check("oor_ack", 32'(ack0), 32'd1);
    check("oor_rdata", rdata0, 32'd0);
    check("oor_flag", 32'(oor0), 32'd1);
    req0 = 1'b0;
    step();
    req0 = 1'b1; addr0 = 12'd1;
    step(); step();
    check("oor_valid_rdata", rdata0, 32'd2);
    check("oor_sticky", 32'(oor0), 32'd1);
    req0 = 1'b0;
    step();

    // Write to 7 at the same edge as the array read of 7
    req0 = 1'b1; addr0 = 12'd7;
    step();
    req0 = 1'b0;
    wr_en0 = 1'b1; wr_addr0 = 12'd7; wr_data0 = 32'h88;
    step();
    wr_en0 = 1'b0;
    check("collide_ack", 32'(ack0), 32'd1);
    check("collide_old", rdata0, 32'h77);
    step();
    req0 = 1'b1; addr0 = 12'd7;
    step(); step();
    check("collide_new", rdata0, 32'h88);
    req0 = 1'b0;
    step();

    // LATENCY=1 instance, 15-bit address
    wr_en1 = 1'b1; wr_addr1 = 15'd20000; wr_data1 = 32'h0000ABCD;
    step();
    wr_en1 = 1'b0;
    req1 = 1'b1; addr1 = 15'd20000;
    step();
    check("lat1_ack", 32'(ack1), 32'd1);
    check("lat1_rdata", rdata1, 32'h0000ABCD);
    check("lat1_oor", 32'(oor1), 32'd0);
    req1 = 1'b0;
    step();
    check("lat1_ack_drop", 32'(ack1), 32'd0);
    check("lat1_txn", 32'(txn1), 32'd1);

    // Reset in WAIT drops the transaction
    req0 = 1'b1; addr0 = 12'd5;
    step();
    check("midrst_busy_pre", 32'(busy0), 32'd1);
    rst_b = 1'b1; req0 = 1'b0;
    step();
    check("midrst_ack", 32'(ack0), 32'd0);
    check("midrst_busy", 32'(busy0), 32'd0);
    check("midrst_txn", 32'(txn0), 32'd0);
    check("midrst_oor", 32'(oor0), 32'd0);
    check("midrst_rdata", rdata0, 32'd0);
    rst_b = 1'b0;
    step();
    check("midrst_no_ack", 32'(ack0), 32'd0);
    req0 = 1'b1; addr0 = 12'd5;
    step(); step();
    check("midrst_reread_ack", 32'(ack0), 32'd1);
    check("midrst_reread", rdata0, 32'hDEADBEEF);
    check("midrst_reread_txn", 32'(txn0), 32'd1);
    req0 = 1'b0;
    step();

`ifdef MEMRESP_STALL_EN
    // Three stalled cycles in WAIT push the ack out by three
    req0 = 1'b1; addr0 = 12'd2;
    step();
    req0 = 1'b0; stall0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_no_ack", 32'(ack0), 32'd0);
      check("stall_busy", 32'(busy0), 32'd1);
    end
    stall0 = 1'b0;
    step();
    check("stall_ack", 32'(ack0), 32'd1);
    check("stall_rdata", rdata0, 32'd3);
    step();
    check("stall_single_ack", 32'(ack0), 32'd0);
    step();
    check("stall_still_idle", 32'(ack0), 32'd0);
    check("stall_txn", 32'(txn0), 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
